// File: rtl/fifo_pkg.sv
// Shared defaults and read-mode encoding for the parameterised FIFO.
package fifo_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 16;

   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_W array, one synchronous write port and one
// asynchronous read port. The array is intentionally not reset.
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store the incoming word on an accepted write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO: wrap-bit pointers, registered occupancy
// count, programmable almost flags, sticky overflow/underflow, and a choice
// of registered or first-word-fall-through read data.
module param_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int AF_LVL = DEPTH - 2,
   parameter int AE_LVL = 2,
   parameter int FWFT   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic                     rd_en,
   input  logic [DATA_W-1:0]        wdata,
   input  logic                     err_clr,
   output logic [DATA_W-1:0]        rdata,
   output logic                     empty,
   output logic                     full,
   output logic                     almost_empty,
   output logic                     almost_full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   localparam fifo_mode_e       MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
   localparam logic [PW-1:0]    ONE  = PW'(1);
   localparam logic [PW-1:0]    AF_C = PW'(AF_LVL);
   localparam logic [PW-1:0]    AE_C = PW'(AE_LVL);

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     count_q,  count_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic              overflow_q,  overflow_d;
   logic              underflow_q, underflow_d;

   logic              wr_acc;
   logic              rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[AW-1:0]),
      .wdata (wdata),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (mem_rdata)
   );

   // Status flags come straight from the registered pointers and count.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                         (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign almost_full  = (count_q >= AF_C);
   assign almost_empty = (count_q <= AE_C);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   assign wr_acc = wr_en && !full;
   assign rd_acc = rd_en && !empty;

   // rdata_q always holds the most recently popped word; in FWFT mode it
   // doubles as the "last head" value shown while the FIFO is empty.
   assign rdata = (MODE == FIFO_FWFT && !empty) ? mem_rdata : rdata_q;

   // Next-state for pointers, count, read register and sticky errors.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rdata_d     = rdata_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ONE;
         rdata_d  = mem_rdata;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase

      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_en && full) begin
         overflow_d = 1'b1;
      end
      if (rd_en && empty) begin
         underflow_d = 1'b1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         rdata_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         rdata_q     <= rdata_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule : param_fifo

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: one registered-read instance and one
// first-word-fall-through instance sharing clock and reset.
module tb_param_fifo;

   logic       clk;
   logic       rst_n;

   logic       wr_en, rd_en, err_clr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       empty, full, almost_empty, almost_full, overflow, underflow;
   logic [4:0] count;

   logic       f_wr_en, f_rd_en, f_err_clr;
   logic [7:0] f_wdata;
   logic [7:0] f_rdata;
   logic       f_empty, f_full, f_almost_empty, f_almost_full, f_overflow, f_underflow;
   logic [4:0] f_count;

   int         n_cmp;
   int         n_err;
   logic [7:0] exp_q[$];
   logic [7:0] exp_w;

   param_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .wdata(wdata),
      .err_clr(err_clr), .rdata(rdata), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   param_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2), .FWFT(1)) dut_fwft (
      .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .rd_en(f_rd_en), .wdata(f_wdata),
      .err_clr(f_err_clr), .rdata(f_rdata), .empty(f_empty), .full(f_full),
      .almost_empty(f_almost_empty), .almost_full(f_almost_full), .count(f_count),
      .overflow(f_overflow), .underflow(f_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0;
      wr_en = 0; rd_en = 0; err_clr = 0; wdata = '0;
      f_wr_en = 0; f_rd_en = 0; f_err_clr = 0; f_wdata = '0;

      // Reset state
      #3;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ae", almost_empty, 1);
      chk("rst_af", almost_full, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);
      chk("rst_f_rdata", f_rdata, 0);
      chk("rst_f_empty", f_empty, 1);
      #9 rst_n = 1'b1;   // released between edges; write on the very next edge

      // Basic write 3 / read 3
      wr_en = 1; wdata = 8'h11; tick();
      wdata = 8'h22; tick();
      wdata = 8'h33; tick();
      wr_en = 0;
      chk("w3_count", count, 3);
      chk("w3_empty", empty, 0);
      chk("w3_ae", almost_empty, 0);
      rd_en = 1; tick();
      chk("r1_rdata", rdata, 8'h11);
      chk("r1_count", count, 2);
      tick();
      chk("r2_rdata", rdata, 8'h22);
      tick();
      rd_en = 0;
      chk("r3_rdata", rdata, 8'h33);
      chk("r3_empty", empty, 1);
      chk("r3_count", count, 0);
      chk("r3_ae", almost_empty, 1);

      // Underflow
      rd_en = 1; tick(); rd_en = 0;
      chk("udf_set", underflow, 1);
      chk("udf_rdata", rdata, 8'h33);
      chk("udf_count", count, 0);
      tick();
      chk("udf_hold", underflow, 1);
      err_clr = 1; tick(); err_clr = 0;
      chk("udf_clr", underflow, 0);

      // Fill to full
      for (int i = 0; i < 16; i++) begin
         wr_en = 1; wdata = 8'h40 + 8'(i);
         exp_q.push_back(wdata);
         tick();
         chk("fill_count", count, i + 1);
         chk("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
         chk("fill_full", full, (i + 1 == 16) ? 1 : 0);
      end
      wdata = 8'hEE; tick(); wr_en = 0;
      chk("ovf_set", overflow, 1);
      chk("ovf_count", count, 16);
      chk("ovf_full", full, 1);
      tick();
      chk("ovf_hold", overflow, 1);
      wr_en = 1; err_clr = 1; tick();
      chk("ovf_set_wins", overflow, 1);
      wr_en = 0; tick(); err_clr = 0;
      chk("ovf_clr", overflow, 0);

      // Read+write while full: read taken, write rejected
      wr_en = 1; rd_en = 1; wdata = 8'hEE; tick();
      wr_en = 0; rd_en = 0;
      exp_w = exp_q.pop_front();
      chk("fullrw_rdata", rdata, exp_w);
      chk("fullrw_count", count, 15);
      chk("fullrw_ovf", overflow, 1);
      err_clr = 1; tick(); err_clr = 0;

      // Drain down to 8
      rd_en = 1;
      for (int i = 0; i < 7; i++) begin
         tick();
         exp_w = exp_q.pop_front();
         chk("drain8_rdata", rdata, exp_w);
      end
      rd_en = 0;
      chk("drain8_count", count, 8);

      // Steady-state simultaneous read/write across pointer wrap
      for (int k = 0; k < 40; k++) begin
         wr_en = 1; rd_en = 1; wdata = 8'h80 + 8'(k);
         exp_q.push_back(wdata);
         tick();
         exp_w = exp_q.pop_front();
         chk("rw_rdata", rdata, exp_w);
         chk("rw_count", count, 8);
      end
      wr_en = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_w = exp_q.pop_front();
         chk("tail_rdata", rdata, exp_w);
      end
      rd_en = 0;
      chk("tail_empty", empty, 1);
      chk("tail_count", count, 0);

      // Read+write while empty: write taken, read rejected
      wr_en = 1; rd_en = 1; wdata = 8'h5A; tick();
      wr_en = 0; rd_en = 0;
      chk("emptyrw_count", count, 1);
      chk("emptyrw_udf", underflow, 1);
      chk("emptyrw_rdata", rdata, 8'hA7);
      rd_en = 1; err_clr = 1; tick(); rd_en = 0; err_clr = 0;
      chk("emptyrw_pop", rdata, 8'h5A);
      chk("emptyrw_udf_clr", underflow, 0);

      // Asynchronous reset with 5 entries stored
      wr_en = 1;
      for (int i = 0; i < 5; i++) begin
         wdata = 8'hC0 + 8'(i); tick();
      end
      wr_en = 0;
      chk("pre_areset_count", count, 5);
      #3 rst_n = 1'b0;
      #1;
      chk("areset_count", count, 0);
      chk("areset_empty", empty, 1);
      chk("areset_ae", almost_empty, 1);
      chk("areset_full", full, 0);
      chk("areset_rdata", rdata, 0);
      #2 rst_n = 1'b1;
      wr_en = 1; wdata = 8'h77; tick(); wr_en = 0;
      chk("postrst_count", count, 1);
      rd_en = 1; tick(); rd_en = 0;
      chk("postrst_rdata", rdata, 8'h77);
      chk("postrst_empty", empty, 1);

      // FWFT instance
      f_wr_en = 1; f_wdata = 8'hA5; tick();
      chk("fwft_rdata", f_rdata, 8'hA5);
      chk("fwft_empty", f_empty, 0);
      f_wdata = 8'hB6; tick(); f_wr_en = 0;
      chk("fwft_head_hold", f_rdata, 8'hA5);
      tick();
      chk("fwft_no_rd", f_rdata, 8'hA5);
      f_rd_en = 1; tick();
      chk("fwft_pop1", f_rdata, 8'hB6);
      chk("fwft_count1", f_count, 1);
      tick(); f_rd_en = 0;
      chk("fwft_pop2_empty", f_empty, 1);
      chk("fwft_last_head", f_rdata, 8'hB6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_param_fifo

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LVL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LVL, default 2, almost_empty threshold (1..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_en  input  1  write request.
REQ-009 SHALL have port rd_en  input  1  read request.
REQ-010 SHALL have port wdata  input  DATA_W  write data.
REQ-011 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-012 SHALL have port rdata  output  DATA_W  read data.
REQ-013 SHALL have ports empty, full, almost_empty, almost_full  output  1 each  status flags.
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Write accepted iff wr_en && !full; word stored at write pointer, pointer +1.
REQ-017 Read accepted iff rd_en && !empty; read pointer +1.
REQ-018 Pointers SHALL be $clog2(DEPTH)+1 bits with wrap bit; full = addresses equal and wrap bits differ; empty = pointers equal.
REQ-019 count SHALL be +1 on write-only accept, -1 on read-only accept, unchanged on both or neither; registered, valid the cycle after the edge.
REQ-020 Simultaneous wr_en and rd_en when full: read accepted, write rejected, overflow set. When empty: write accepted, read rejected, underflow set.
REQ-021 Simultaneous accepted read and write at 0<count<DEPTH: both take effect, count unchanged.
REQ-022 FWFT=0: rdata registered, updated one cycle after read accept with the popped word; holds value otherwise.
REQ-023 FWFT=1: rdata SHALL equal the head entry whenever !empty (zero-latency); rd_en pops it; value undefined-but-stable (last head) when empty.
REQ-024 almost_full = (count >= AF_LVL); almost_empty = (count <= AE_LVL); both derived from registered count.
REQ-025 overflow set on cycle wr_en && full; underflow set on cycle rd_en && empty; both held until err_clr; set wins over err_clr in the same cycle.
REQ-026 Rejected accesses SHALL not modify memory, pointers or count.
REQ-027 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data ordering strictly first-in first-out across wrap.

Reset
REQ-028 On rst_n low, immediately and regardless of clk: pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rdata=0, overflow=0, underflow=0.
REQ-029 Reset mid-operation SHALL discard all stored entries; storage array itself not reset.
REQ-030 Deassertion of rst_n SHALL need no clk cycle before first accepted write.

Structure
REQ-031 Package fifo_pkg SHALL hold default constants (DEF_DATA_W=8, DEF_DEPTH=16) and a mode enum {FIFO_STD, FIFO_FWFT}.
REQ-032 Storage SHALL be a sub-module fifo_mem (DEPTH x DATA_W, one write port, one asynchronous read port); pointer/flag logic in param_fifo.

Verification
REQ-033 Reset, then write 0x11,0x22,0x33, read 3 (FWFT=0) -> rdata 0x11,0x22,0x33 each one cycle after rd_en; empty=1, count=0 at end.
REQ-034 DEPTH=16: write 16 words -> full=1 at count 16, almost_full=1 from count 14; 17th write -> no store, overflow=1 until err_clr.
REQ-035 Read when empty -> underflow=1, rdata unchanged, count=0; err_clr pulse -> underflow=0.
REQ-036 count=8, wr_en and rd_en together for 40 cycles with incrementing data -> count stays 8, all data returned in order across pointer wrap.
REQ-037 FWFT=1: write 0xA5 -> rdata=0xA5 with empty=0 next cycle without rd_en; rd_en pops -> empty=1.
REQ-038 Assert rst_n low between clk edges with count=5 -> count=0, empty=1, flags cleared immediately.
